// File: rtl/riscv_branch_pkg.sv
// Shared types and constants for the branch redirect path.
package riscv_branch_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned FCNT_W  = 3;
    localparam logic [XLEN-1:0] PC_INCR = 64'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_e;

    // A fetch target is usable only when word aligned.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch/jump target: base + (imm << IMM_SHIFT), modulo 2^XLEN.
module branch_target_adder
    import riscv_branch_pkg::*;
#(
    parameter int unsigned IMM_SHIFT = 1
) (
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_imm_shifted;

    assign w_imm_shifted = i_imm << IMM_SHIFT;
    assign o_target      = i_base + w_imm_shifted;

endmodule

// File: rtl/branch_redirect_unit.sv
// Owns the fetch PC: applies taken-branch redirects, sequences the post-redirect
// pipeline flush and keeps saturating branch statistics.
module branch_redirect_unit
    import riscv_branch_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned IMM_SHIFT    = 1,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_pc,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc_out,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e         r_state;
    logic [FCNT_W-1:0] r_fcnt;
    logic [XLEN-1:0]   r_pc;
    logic              r_flush;
    logic              r_redirect;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_seq_pc;
    logic              w_taken;
    logic              w_target_ok;

    branch_target_adder #(
        .IMM_SHIFT (IMM_SHIFT)
    ) u_target_adder (
        .i_base   (branch_pc),
        .i_imm    (imm),
        .o_target (w_target)
    );

    assign w_taken     = branch_valid & branch_taken;
    assign w_target_ok = is_aligned(w_target);
    // Stall holds the PC; otherwise advance one instruction (wraps at 2^64).
    assign w_seq_pc    = stall ? r_pc : (r_pc + PC_INCR);

    // Redirect/flush state machine, PC register and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_fcnt       <= '0;
            r_pc         <= RESET_PC;
            r_flush      <= 1'b0;
            r_redirect   <= 1'b0;
            r_misalign   <= 1'b0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (branch_valid && (r_branch_cnt != {CNT_W{1'b1}})) begin
                        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                    end
                    if (w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
                    end
                    // A usable taken target beats the stall.
                    if (w_taken && w_target_ok) begin
                        r_pc       <= w_target;
                        r_redirect <= 1'b1;
                        r_flush    <= 1'b1;
                        r_fcnt     <= FCNT_W'(FLUSH_CYCLES);
                        r_state    <= ST_FLUSH;
                    end else begin
                        r_pc <= w_seq_pc;
                        if (w_taken) begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path branches are ignored; stall does not extend the flush.
                    r_pc <= w_seq_pc;
                    if (r_fcnt <= FCNT_W'(1)) begin
                        r_fcnt  <= '0;
                        r_flush <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_fcnt <= r_fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign flush_if_id  = r_flush;
    assign flush_id_ex  = r_flush;
    assign redirect     = r_redirect;
    assign misalign_err = r_misalign;
    assign branch_cnt   = r_branch_cnt;
    assign taken_cnt    = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized + directed check of branch_redirect_unit against a cycle-level reference model.
module tb_branch_redirect_unit;

    localparam int unsigned CW  = 4;
    localparam int unsigned FC  = 2;
    localparam int unsigned SH  = 1;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall, branch_valid, branch_taken;
    logic [63:0]   branch_pc, imm;
    logic [63:0]   pc_out;
    logic          flush_if_id, flush_id_ex, redirect, misalign_err;
    logic [CW-1:0] branch_cnt, taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_pc;
    int          m_flush_left;
    bit          m_red, m_mis;
    int          m_bc, m_tc;

    branch_redirect_unit #(
        .RESET_PC     (64'h0),
        .IMM_SHIFT    (SH),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .imm          (imm),
        .pc_out       (pc_out),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .redirect     (redirect),
        .misalign_err (misalign_err),
        .branch_cnt   (branch_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the architectural rules, written from the behavioural description.
    task automatic model_step(input bit rst, input bit st, input bit bv, input bit bt,
                              input logic [63:0] bpc, input logic [63:0] im);
        logic [63:0] tgt;
        bit          jump;
        jump = 1'b0;
        if (rst) begin
            m_pc = 64'h0; m_flush_left = 0; m_red = 0; m_mis = 0; m_bc = 0; m_tc = 0;
            return;
        end
        m_red = 0;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (bv) begin
            m_bc = (m_bc < SAT) ? m_bc + 1 : SAT;
            if (bt) begin
                m_tc = (m_tc < SAT) ? m_tc + 1 : SAT;
                tgt  = bpc + (im * (64'd1 << SH));
                if (tgt % 4 == 0) jump = 1'b1;
                else              m_mis = 1;
            end
        end
        if (jump) begin
            m_pc = tgt; m_red = 1; m_flush_left = FC;
        end else if (!st) begin
            m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit bv, input bit bt,
                        input logic [63:0] bpc, input logic [63:0] im);
        reset = rst; stall = st; branch_valid = bv; branch_taken = bt;
        branch_pc = bpc; imm = im;
        @(posedge clk);
        model_step(rst, st, bv, bt, bpc, im);
        #1;
        check_val("pc_out",       pc_out,       m_pc);
        check_val("flush_if_id",  64'(flush_if_id), 64'(m_flush_left > 0));
        check_val("flush_id_ex",  64'(flush_id_ex), 64'(m_flush_left > 0));
        check_val("redirect",     64'(redirect),     64'(m_red));
        check_val("misalign_err", 64'(misalign_err), 64'(m_mis));
        check_val("branch_cnt",   64'(branch_cnt),   64'(m_bc));
        check_val("taken_cnt",    64'(taken_cnt),    64'(m_tc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'h0, 64'h0);
    endtask

    initial begin
        logic [63:0] rpc, rimm;
        reset = 1; stall = 0; branch_valid = 0; branch_taken = 0;
        branch_pc = '0; imm = '0;

        // Reset then idle counting 4, 8, 12
        step(1, 0, 0, 0, 64'h0, 64'h0);
        check_val("reset_pc", pc_out, 64'h0);
        idle(3);
        check_val("idle_pc12", pc_out, 64'd12);

        // Reach 0x100, then branch 0x100 + (0x10<<1) = 0x120
        step(0, 0, 1, 1, 64'h0, 64'h80);
        idle(2);
        step(0, 0, 1, 1, 64'h100, 64'h10);
        check_val("target_0x120", pc_out, 64'h120);
        check_val("redirect_pulse", 64'(redirect), 64'd1);
        idle(3);

        // Taken branch under stall still redirects; stall inside FLUSH holds PC
        step(0, 1, 1, 1, 64'h400, 64'h20);
        check_val("stall_redirect", pc_out, 64'h440);
        step(0, 1, 0, 0, 64'h0, 64'h0);
        step(0, 0, 0, 0, 64'h0, 64'h0);
        check_val("flush_done", 64'(flush_if_id), 64'd0);

        // Misaligned target 0x202: no redirect, sticky error
        step(0, 0, 1, 1, 64'h200, 64'h1);
        check_val("misalign_set", 64'(misalign_err), 64'd1);
        idle(2);

        // Wrong-path branch during flush ignored, then reset mid-flush
        step(0, 0, 1, 1, 64'h800, 64'h8);
        step(0, 0, 1, 1, 64'h900, 64'h8);
        step(1, 0, 1, 1, 64'h900, 64'h8);
        check_val("reset_in_flush", pc_out, 64'h0);

        // Counter saturation: 20 not-taken branches
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 64'h0, 64'h0);
        check_val("bcnt_sat", 64'(branch_cnt), 64'(SAT));

        // PC wrap: redirect to ...FFFC then +4 wraps to 0
        step(0, 0, 1, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("pc_fffc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 64'h0, 64'h0);
        check_val("pc_wrap", pc_out, 64'h0);
        idle(2);

        // Random traffic
        step(1, 0, 0, 0, 64'h0, 64'h0);
        for (int i = 0; i < 600; i++) begin
            rpc  = {$urandom, $urandom} & ~64'h3;
            rimm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                               : 64'($signed(12'($urandom)));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0), rpc, rimm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
